// File: rtl/fadd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fadd_arbiter
// Description : Round-robin share of one combinational fadd32 adder between
//               two requesters with valid/ready request and response sides.
// Revision    : 1.0 - initial release
// ============================================================================
module fadd_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic [31:0] fadd_a,
    output logic [31:0] fadd_b,
    input  logic [31:0] fadd_result,
    output logic        busy,
    output logic        grant_id
);

    localparam logic [3:0] c_CNT_LOAD = 4'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ptr;
    logic        w_ptr_nxt;
    logic        r_owner;
    logic        w_owner_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_op_a;
    logic [31:0] w_op_a_nxt;
    logic [31:0] r_op_b;
    logic [31:0] w_op_b_nxt;
    logic [31:0] r_result;
    logic [31:0] w_result_nxt;

    logic        w_grant_vld;
    logic        w_grant_id;
    logic        w_idle;
    logic        w_accept;
    logic        w_rsp_hs;

    // Pointer only breaks ties; a lone requester always wins.
    always_comb begin
        w_grant_vld = req0_valid | req1_valid;
        w_grant_id  = (req0_valid && req1_valid) ? r_ptr : req1_valid;
        w_idle      = (r_state == ST_IDLE);
        w_accept    = w_idle && w_grant_vld;
        w_rsp_hs    = r_owner ? rsp1_ready : rsp0_ready;
    end

    // Ready is combinational from valid, so hold it low while reset is active.
    assign req0_ready  = reset_n && w_accept && !w_grant_id;
    assign req1_ready  = reset_n && w_accept &&  w_grant_id;

    assign rsp0_valid  = (r_state == ST_RESP) && !r_owner;
    assign rsp1_valid  = (r_state == ST_RESP) &&  r_owner;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;

    assign fadd_a      = r_op_a;
    assign fadd_b      = r_op_b;
    assign busy        = !w_idle;
    assign grant_id    = r_owner;

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_owner_nxt  = r_owner;
        w_cnt_nxt    = r_cnt;
        w_op_a_nxt   = r_op_a;
        w_op_b_nxt   = r_op_b;
        w_result_nxt = r_result;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_op_a_nxt  = w_grant_id ? req1_a : req0_a;
                    w_op_b_nxt  = w_grant_id ? req1_b : req0_b;
                    w_owner_nxt = w_grant_id;
                    w_ptr_nxt   = !w_grant_id;
                    w_cnt_nxt   = c_CNT_LOAD;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Operands have been stable for EXEC_CYCLES cycles at cnt==0.
                if (r_cnt == 4'd0) begin
                    w_result_nxt = fadd_result;
                    w_state_nxt  = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 1'b0;
            r_owner  <= 1'b0;
            r_cnt    <= 4'd0;
            r_op_a   <= 32'd0;
            r_op_b   <= 32'd0;
            r_result <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_cnt    <= w_cnt_nxt;
            r_op_a   <= w_op_a_nxt;
            r_op_b   <= w_op_b_nxt;
            r_result <= w_result_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fadd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fadd_arbiter
// Description : Self-checking bench for fadd_arbiter, EXEC_CYCLES 1 and 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fadd_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid  [2][2];
    logic        req_ready  [2][2];
    logic [31:0] req_a      [2][2];
    logic [31:0] req_b      [2][2];
    logic        rsp_valid  [2][2];
    logic        rsp_ready  [2][2];
    logic [31:0] rsp_result [2][2];
    logic [31:0] fadd_a      [2];
    logic [31:0] fadd_b      [2];
    logic [31:0] fadd_result [2];
    logic        busy        [2];
    logic        grant_id    [2];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        id;
        logic [31:0] sum;
    } exp_t;
    exp_t sb0[$];
    exp_t sb1[$];

    typedef struct {
        int          d;
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          hold;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    // Stand-in for the shared adder: exact sums for the named pairs, otherwise
    // an arbitrary bit pattern (the block must pass it through unchanged).
    function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h40400000;
            64'h40A00000_3F800000: return 32'h40C00000;
            64'h40000000_40000000: return 32'h40800000;
            64'h3F800000_3F800000: return 32'h40000000;
            default:               return (a ^ {b[15:0], b[31:16]}) + 32'h0001_2345;
        endcase
    endfunction

    function automatic int exec_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        fadd_arbiter #(.EXEC_CYCLES(d == 0 ? 1 : 4)) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .req0_valid  (req_valid[d][0]),
            .req0_ready  (req_ready[d][0]),
            .req0_a      (req_a[d][0]),
            .req0_b      (req_b[d][0]),
            .rsp0_valid  (rsp_valid[d][0]),
            .rsp0_ready  (rsp_ready[d][0]),
            .rsp0_result (rsp_result[d][0]),
            .req1_valid  (req_valid[d][1]),
            .req1_ready  (req_ready[d][1]),
            .req1_a      (req_a[d][1]),
            .req1_b      (req_b[d][1]),
            .rsp1_valid  (rsp_valid[d][1]),
            .rsp1_ready  (rsp_ready[d][1]),
            .rsp1_result (rsp_result[d][1]),
            .fadd_a      (fadd_a[d]),
            .fadd_b      (fadd_b[d]),
            .fadd_result (fadd_result[d]),
            .busy        (busy[d]),
            .grant_id    (grant_id[d])
        );
        assign fadd_result[d] = fadd_model(fadd_a[d], fadd_b[d]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin : p_monitor
        exp_t e;
        if (!reset_n) begin
            sb0.delete();
            sb1.delete();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (rsp_valid[d][0] || rsp_valid[d][1])
                    check("rsp_onehot", 32'(rsp_valid[d][0] && rsp_valid[d][1]), 32'd0);
                for (int x = 0; x < 2; x++) begin
                    if (req_valid[d][x] && req_ready[d][x]) begin
                        e.id  = 1'(x);
                        e.sum = fadd_model(req_a[d][x], req_b[d][x]);
                        if (d == 0) sb0.push_back(e);
                        else        sb1.push_back(e);
                    end
                    if (rsp_valid[d][x] && rsp_ready[d][x]) begin
                        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                            check("sb_underflow", 32'd1, 32'd0);
                        end else begin
                            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                            check("sb_owner", 32'(e.id), 32'(x));
                            check("sb_result", rsp_result[d][x], e.sum);
                        end
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int x = 0; x < 2; x++) begin
                req_valid[d][x] = 1'b0;
                rsp_ready[d][x] = 1'b0;
                req_a[d][x]     = 32'd0;
                req_b[d][x]     = 32'd0;
            end
        end
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d][0] = 1'b1;
            req_valid[d][1] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_grant", 32'(grant_id[d]), 32'd0);
            check("rst_fadd_a", fadd_a[d], 32'd0);
            check("rst_fadd_b", fadd_b[d], 32'd0);
            check("rst_rsp_valid", 32'({rsp_valid[d][0], rsp_valid[d][1]}), 32'd0);
            check("rst_rsp_result", rsp_result[d][0] | rsp_result[d][1], 32'd0);
            check("rst_req_ready", 32'({req_ready[d][0], req_ready[d][1]}), 32'd0);
        end
        clear_inputs();
        reset_n = 1'b1;
    endtask

    task automatic do_op(input int d, input logic id, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int hold);
        int n;
        req_a[d][id]     = a;
        req_b[d][id]     = b;
        req_valid[d][id] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[d][id] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("req_ready", 32'(req_ready[d][id]), 32'd1);
        @(posedge clk); #1;
        req_valid[d][id] = 1'b0;
        n = 0;
        while (!rsp_valid[d][id] && n < 40) begin
            check("fadd_a_exec", fadd_a[d], a);
            check("fadd_b_exec", fadd_b[d], b);
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'(exec_of(d)));
        check("rsp_result", rsp_result[d][id], exp);
        check("rsp_other_valid", 32'(rsp_valid[d][!id]), 32'd0);
        check("grant_id", 32'(grant_id[d]), 32'(id));
        // Non-owner ready must not complete the response.
        rsp_ready[d][!id] = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid[d][id]), 32'd1);
            check("hold_result", rsp_result[d][id], exp);
            check("hold_busy", 32'(busy[d]), 32'd1);
            check("hold_fadd_a", fadd_a[d], a);
        end
        rsp_ready[d][id] = 1'b1;
        @(posedge clk); #1;
        check("hs_busy", 32'(busy[d]), 32'd0);
        check("hs_valid", 32'(rsp_valid[d][id]), 32'd0);
        rsp_ready[d][0] = 1'b0;
        rsp_ready[d][1] = 1'b0;
    endtask

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : p_main
        int          n;
        logic        seen;
        logic        exp_g;
        logic [31:0] val;

        vecs[0] = '{0, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 0};
        vecs[1] = '{0, 1'b1, 32'h40000000, 32'h40000000, 32'h40800000, 2};
        vecs[2] = '{0, 1'b1, 32'h3F800000, 32'h3F800000, 32'h40000000, 0};
        vecs[3] = '{0, 1'b0, 32'hC0490FDB, 32'h3F800000, 32'h0, 1};
        vecs[4] = '{0, 1'b0, 32'h7F800000, 32'hFF800000, 32'h0, 0};
        vecs[5] = '{0, 1'b1, 32'h00000000, 32'h80000000, 32'h0, 3};
        vecs[6] = '{1, 1'b1, 32'h40A00000, 32'h3F800000, 32'h40C00000, 0};
        vecs[7] = '{1, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1};
        for (int i = 3; i < 8; i++) begin
            if (i != 6) vecs[i].exp = fadd_model(vecs[i].a, vecs[i].b);
        end

        apply_reset();
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].d, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);
        end

        // Backpressure on requester 0 while requester 1 waits.
        req_a[0][0] = 32'h3F800000; req_b[0][0] = 32'h3F800000; req_valid[0][0] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[0][0] && n < 20) begin @(posedge clk); #1; n++; end
        check("bp_ready0", 32'(req_ready[0][0]), 32'd1);
        @(posedge clk); #1;
        req_valid[0][0] = 1'b0;
        req_a[0][1] = 32'h40000000; req_b[0][1] = 32'h40000000; req_valid[0][1] = 1'b1;
        n = 0;
        while (!rsp_valid[0][0] && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid[0][0]), 32'd1);
            check("bp_result", rsp_result[0][0], 32'h40000000);
            check("bp_ready", 32'({req_ready[0][0], req_ready[0][1]}), 32'd0);
            check("bp_busy", 32'(busy[0]), 32'd1);
            @(posedge clk); #1;
        end
        rsp_ready[0][0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0][0] = 1'b0;
        check("bp_idle", 32'(busy[0]), 32'd0);
        check("bp_next_grant", 32'(req_ready[0][1]), 32'd1);
        rsp_ready[0][1] = 1'b1;
        @(posedge clk); #1;
        req_valid[0][1] = 1'b0;
        check("bp_next_owner", 32'(grant_id[0]), 32'd1);
        n = 0;
        while (busy[0] && n < 20) begin @(posedge clk); #1; n++; end
        check("bp_done", 32'(busy[0]), 32'd0);
        rsp_ready[0][1] = 1'b0;

        // Fairness under continuous requests from both sides.
        apply_reset();
        for (int x = 0; x < 2; x++) begin
            req_a[0][x] = 32'h3F800000 + 32'(x);
            req_b[0][x] = 32'h40000000;
            req_valid[0][x] = 1'b1;
            rsp_ready[0][x] = 1'b1;
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_g = 1'(k);
            n = 0;
            while (!(req_ready[0][0] || req_ready[0][1]) && n < 30) begin
                @(posedge clk); #1; n++;
            end
            check("fair_ready", 32'(req_ready[0][exp_g]), 32'd1);
            @(posedge clk); #1;
            check("fair_grant", 32'(grant_id[0]), 32'(exp_g));
            val = 32'h40000000 + 32'(k * 16);
            req_a[0][exp_g] = val;
        end
        req_valid[0][0] = 1'b0;
        req_valid[0][1] = 1'b0;
        n = 0;
        while (busy[0] && n < 20) begin @(posedge clk); #1; n++; end
        check("fair_done", 32'(busy[0]), 32'd0);
        rsp_ready[0][0] = 1'b0;
        rsp_ready[0][1] = 1'b0;

        // Asynchronous reset in the middle of EXEC (EXEC_CYCLES=4 instance).
        req_a[1][1] = 32'h40A00000; req_b[1][1] = 32'h3F800000; req_valid[1][1] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[1][1] && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid[1][1] = 1'b0;
        @(posedge clk); #1;
        check("mid_busy_pre", 32'(busy[1]), 32'd1);
        #2;
        reset_n = 1'b0;
        req_valid[1][1] = 1'b1;
        #1;
        check("mid_busy", 32'(busy[1]), 32'd0);
        check("mid_grant", 32'(grant_id[1]), 32'd0);
        check("mid_fadd_a", fadd_a[1], 32'd0);
        check("mid_fadd_b", fadd_b[1], 32'd0);
        check("mid_rsp_valid", 32'({rsp_valid[1][0], rsp_valid[1][1]}), 32'd0);
        check("mid_req_ready", 32'(req_ready[1][1]), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        req_valid[1][1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid[1][0] | rsp_valid[1][1] | busy[1];
        end
        check("mid_no_rsp", 32'(seen), 32'd0);
        req_a[1][0] = 32'h3F800000; req_b[1][0] = 32'h40000000;
        req_valid[1][0] = 1'b1;
        req_valid[1][1] = 1'b1;
        #1;
        check("mid_ptr_req0", 32'(req_ready[1][0]), 32'd1);
        check("mid_ptr_req1", 32'(req_ready[1][1]), 32'd0);
        @(posedge clk); #1;
        req_valid[1][0] = 1'b0;
        req_valid[1][1] = 1'b0;
        rsp_ready[1][0] = 1'b1;
        n = 0;
        while (busy[1] && n < 20) begin @(posedge clk); #1; n++; end
        check("mid_done", 32'(busy[1]), 32'd0);
        rsp_ready[1][0] = 1'b0;

        @(posedge clk); #1;
        check("sb0_empty", 32'(sb0.size()), 32'd0);
        check("sb1_empty", 32'(sb1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fadd_arbiter.md
Name: fadd_arbiter

Overview:
Shares one combinational fadd32 single-precision adder between two requesters, using round-robin arbitration and valid/ready handshakes on both the request and response sides. The block drives the adder operands from internal registers, holds them stable for a configurable number of cycles, then captures the sum. It returns the sum to the requester that issued the operation. It sits between the issue logic and the adder in the FP datapath.

Parameters:
EXEC_CYCLES, 1, cycles operands are held on the adder before the sum is captured (multicycle-path allowance); legal range 1..15.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle
req0_a  in  32  requester 0 operand A (IEEE-754 single)
req0_b  in  32  requester 0 operand B
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 takes the result
rsp0_result  out  32  sum for requester 0
req1_valid, req1_ready, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_result: same as the requester 0 ports, for requester 1
fadd_a  out  32  operand A to the shared adder
fadd_b  out  32  operand B to the shared adder
fadd_result  in  32  combinational sum from the shared adder
busy  out  1  operation in flight (state != IDLE)
grant_id  out  1  owner of the current or last operation

Behaviour:
- Reset (async, reset_n=0):
  - State is IDLE.
  - Round-robin pointer = 0.
  - Owner, cycle counter, operand registers and result register are all 0.
  - Outputs: all ready/valid = 0, fadd_a = fadd_b = 0, rsp*_result = 0, busy = 0, grant_id = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection (combinational):
  - Both valid: grant the requester named by the pointer.
  - One valid: grant that requester.
  - None valid: no grant.
  - reqX_ready = (state==IDLE) && grant==X. Ready never asserts outside IDLE.
- IDLE, accept (reqX_valid && reqX_ready at a clock edge):
  - Latch reqX_a and reqX_b into the operand registers.
  - owner <= X, pointer <= ~X, cnt <= EXEC_CYCLES-1, state -> EXEC.
- EXEC:
  - fadd_a/fadd_b = operand registers, stable for the whole state.
  - cnt decrements each cycle.
  - At the edge where cnt==0: result register <= fadd_result, state -> RESP.
- RESP:
  - rspX_valid = 1 for X = owner only; the other rsp_valid = 0.
  - rspX_result = result register for the owner.
  - Result and valid hold stable until rspX_ready.
  - On the handshake edge, state -> IDLE.
  - The non-owner's rsp_ready is ignored.
- Timing:
  - Accept edge to rsp_valid high is EXEC_CYCLES cycles.
  - No IDLE bypass: the next accept happens no earlier than the cycle after the response handshake.
  - Peak throughput is one operation per EXEC_CYCLES+2 cycles.
- Output behaviour outside the active states:
  - fadd_a/fadd_b keep their last values in IDLE and RESP (operand registers are not cleared).
  - rsp*_result holds the last result; it is meaningful only while valid.
- Fairness: under continuous requests from both sides, grants alternate 0,1,0,1. A lone requester is served back-to-back.
- Requesters must hold a/b stable while valid. The block samples operands only on the accept edge.
- No arithmetic beyond the 4-bit counter; the sum passes through bit-exact.
- Reset mid-operation (EXEC or RESP): the operation is dropped, no response is issued, and the block returns to the reset state immediately.

Test Plan:
- EXEC_CYCLES=1; req0 a=0x3F800000, b=0x40000000 (1.0+2.0):
  - req0_ready=1 in the same cycle.
  - rsp0_valid rises 1 cycle after accept, with rsp0_result=0x40400000.
  - rsp0_ready=1 returns busy to 0.
- Both valid after reset, continuous, rsp_ready=1: grant_id sequence 0,1,0,1. Each result goes only to its own rsp port; the other rsp_valid stays 0.
- Backpressure: hold rsp0_ready=0 for 5 cycles in RESP:
  - rsp0_valid and rsp0_result stay stable.
  - req0_ready and req1_ready stay 0; busy stays 1.
  - Releasing rsp0_ready completes the handshake, and the next grant follows in IDLE.
- EXEC_CYCLES=4; req1 a=0x40A00000, b=0x3F800000 (5.0+1.0):
  - fadd_a/fadd_b equal the operands for 4 cycles.
  - rsp1_valid rises 4 cycles after accept, with rsp1_result=0x40C00000.
- Drive reset_n low during EXEC: all outputs go to 0 without a clock edge and no rsp_valid appears. After release, req1 is granted first when both are valid? No: the pointer is 0, so req0 is granted first.
- Owner=0 in RESP with rsp1_ready=1 and rsp0_ready=0: the state stays RESP and rsp0_valid stays 1.
